wshb_mire_gen: RTL and testbench

- Wishbone master test-pattern generator on the stream bus, upstream of the framebuffer/SDRAM controller.
- Continuously writes one 32-bit pixel per word, raster order, into an HDISP x VDISP framebuffer; the VGA reader consumes this frame downstream.
- Splits traffic into bounded bursts separated by idle gaps so the display reader keeps bus access.
- Single clock domain: sys_clk.

---
 rtl/wshb_mire_gen_pkg.sv | 46 ++++
 rtl/wshb_mire_gen_pattern.sv | 62 ++++++
 rtl/wshb_mire_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_wshb_mire_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_mire_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mire_pkg
//  Description : Shared types and constants for the Wishbone test-pattern
//                generator: pixel colour struct, pattern and FSM state
//                enumerations, and the colour-bar palette.
//  Revision    : 1.0 - initial release
// ============================================================================
package mire_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    SOLID    = 2'd2,
    GRADIENT = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam rgb_t RGB_WHITE = 24'hFF_FF_FF;
  localparam rgb_t RGB_BLACK = 24'h00_00_00;

  // Index 0 is the leftmost bar.
  localparam rgb_t [0:7] BAR_COLOURS = {
    24'hFF_FF_FF,  // white
    24'hFF_FF_00,  // yellow
    24'h00_FF_FF,  // cyan
    24'h00_FF_00,  // green
    24'hFF_00_FF,  // magenta
    24'hFF_00_00,  // red
    24'h00_00_FF,  // blue
    24'h00_00_00   // black
  };

endpackage
`default_nettype wire

// File: rtl/wshb_mire_gen_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : mire_pattern
//  Description : Combinational pixel colour generator. Maps a (possibly
//                offset) column x, a line y and a pattern selector to an
//                RGB value.
//  Ports       : x         in  column used for the pattern
//                y         in  line number
//                pattern   in  pattern selector
//                solid_rgb in  colour for the solid pattern
//                rgb       out resulting pixel colour
//  Revision    : 1.0 - initial release
// ============================================================================
module mire_pattern
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pattern_e      pattern,
  input  rgb_t          solid_rgb,
  output rgb_t          rgb
);

  localparam int BAR_W = HDISP / 8;

  logic [31:0] xe;
  logic [31:0] ye;
  logic [2:0]  bar;
  logic        chk_white;

  always_comb begin
    xe = 32'(x);
    ye = 32'(y);

    // Bar index = number of bar boundaries at or left of x; the last bar
    // keeps anything beyond 7*BAR_W, so it absorbs the remainder.
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (xe >= 32'(k * BAR_W)) begin
        bar = 3'(k);
      end
    end

    // White where bit 4 of x and y differ (16x16 squares).
    chk_white = ((xe ^ ye) & 32'h0000_0010) != 32'h0;

    rgb = RGB_BLACK;
    case (pattern)
      BARS:     rgb = BAR_COLOURS[bar];
      CHECKER:  rgb = chk_white ? RGB_WHITE : RGB_BLACK;
      SOLID:    rgb = solid_rgb;
      GRADIENT: rgb = '{r: xe[7:0], g: xe[7:0], b: xe[7:0]};
      default:  rgb = RGB_BLACK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wshb_mire_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_mire_gen
//  Description : Wishbone master that continuously writes a test pattern
//                into an HDISP x VDISP framebuffer in raster order, one
//                32-bit pixel {8'h00,R,G,B} per word, in bursts of
//                BURST_LEN accepted transfers separated by PAUSE_CYCLES
//                idle cycles.
//  Ports       : sys_clk, sys_rst       clock, async active-high reset
//                enable                 generation enable
//                pattern_sel, solid_rgb pattern choice, latched at pixel (0,0)
//                wshb_*                 Wishbone classic master interface
//                frame_done             pulse after last pixel of a frame
//  Options     : MIRE_ANIM_EN - horizontal pattern scroll by one pixel per
//                frame (address generation is unaffected).
//  Revision    : 1.0 - initial release
// ============================================================================
module wshb_mire_gen
  import mire_pkg::*;
#(
  parameter int          HDISP        = 800,
  parameter int          VDISP        = 480,
  parameter int          BURST_LEN    = 64,
  parameter int          PAUSE_CYCLES = 2,
  parameter logic [31:0] BASE_ADR     = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic        wshb_err,
  input  logic        wshb_rty,
  output logic        frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  state_e         state, state_nx;
  logic [XW-1:0]  x, x_nx, px, xp;
  logic [YW-1:0]  y, y_nx, py;
  logic [CW-1:0]  burst_cnt;
  logic [PW-1:0]  pause_cnt;
  logic           accept, last_x, last_y, last_pix;
  logic           burst_end, pause_end, load, first_pix;
  pattern_e       pat_q, pat_use;
  rgb_t           solid_q, solid_use, pix_rgb;

  assign wshb_sel = 4'hF;
  assign wshb_cti = 3'b000;
  assign wshb_bte = 2'b00;

  // err/rty take priority over ack: the transfer is simply retried.
  assign accept    = (state == WRITE) && wshb_ack && !wshb_err && !wshb_rty;
  assign last_x    = (x == XW'(HDISP - 1));
  assign last_y    = (y == YW'(VDISP - 1));
  assign last_pix  = last_x && last_y;
  assign burst_end = (burst_cnt == CW'(BURST_LEN - 1));
  assign pause_end = (pause_cnt == PW'(PAUSE_CYCLES - 1));
  assign x_nx      = last_x ? '0 : x + 1'b1;
  assign y_nx      = last_x ? (last_y ? '0 : y + 1'b1) : y;

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // load: adr/dat registers take the pixel that will be on the bus next.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = WRITE;
          load     = 1'b1;
        end
      end
      WRITE: begin
        if (accept) begin
          load = 1'b1;
          if (burst_end) begin
            state_nx = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (pause_end) begin
          if (enable) begin
            state_nx = WRITE;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Pixel to be issued next: the advanced position when a transfer is
  // accepted this cycle, otherwise the current one.
  // ------------------------------------------------------------------------
  always_comb begin
    px        = accept ? x_nx : x;
    py        = accept ? y_nx : y;
    first_pix = (px == '0) && (py == '0);
    // Pattern inputs are only sampled at the start of a frame.
    pat_use   = first_pix ? pattern_e'(pattern_sel) : pat_q;
    solid_use = first_pix ? rgb_t'(solid_rgb) : solid_q;
  end

`ifdef MIRE_ANIM_EN
  localparam logic [XW:0] HDISP_EXT = (XW + 1)'(HDISP);

  logic [XW-1:0] offset, offset_use;
  logic [XW:0]   xsum;

  // The first pixel of the next frame is loaded on the same edge that the
  // offset advances, so it must already see the advanced offset.
  always_comb begin
    offset_use = offset;
    if (accept && last_pix) begin
      offset_use = (offset == XW'(HDISP - 1)) ? '0 : offset + 1'b1;
    end
    xsum = {1'b0, px} + {1'b0, offset_use};
    if (xsum >= HDISP_EXT) begin
      xsum = xsum - HDISP_EXT;
    end
    xp = xsum[XW-1:0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      offset <= '0;
    end else begin
      offset <= offset_use;
    end
  end
`else
  assign xp = px;
`endif

  mire_pattern #(
    .HDISP (HDISP),
    .XW    (XW),
    .YW    (YW)
  ) u_pattern (
    .x         (xp),
    .y         (py),
    .pattern   (pat_use),
    .solid_rgb (solid_use),
    .rgb       (pix_rgb)
  );

  // ------------------------------------------------------------------------
  // Counters and registered bus outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wshb_cyc    <= 1'b0;
      wshb_stb    <= 1'b0;
      wshb_we     <= 1'b0;
      wshb_adr    <= BASE_ADR;
      wshb_dat_ms <= 32'h0;
      frame_done  <= 1'b0;
      x           <= '0;
      y           <= '0;
      burst_cnt   <= '0;
      pause_cnt   <= '0;
      pat_q       <= BARS;
      solid_q     <= RGB_BLACK;
    end else begin
      wshb_cyc   <= (state_nx == WRITE);
      wshb_stb   <= (state_nx == WRITE);
      wshb_we    <= (state_nx == WRITE);
      frame_done <= accept && last_pix;

      if (accept) begin
        x         <= x_nx;
        y         <= y_nx;
        // Running word address; wraps to the frame base instead of
        // recomputing y*HDISP+x.
        wshb_adr  <= last_pix ? BASE_ADR : wshb_adr + 32'd4;
        burst_cnt <= burst_end ? '0 : burst_cnt + 1'b1;
      end

      if (load) begin
        wshb_dat_ms <= {8'h00, pix_rgb};
        if (first_pix) begin
          pat_q   <= pat_use;
          solid_q <= solid_use;
        end
      end

      if (state == PAUSE) begin
        pause_cnt <= pause_cnt + 1'b1;
      end else begin
        pause_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wshb_mire_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wshb_mire_gen
//  Description : Self-checking bench for wshb_mire_gen on an 8x4 frame with
//                4-transfer bursts and 2-cycle pauses. A Wishbone slave model
//                answers from the bench; a pixel-index reference model
//                predicts every address, data word and frame_done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_mire_gen;

  localparam int          H    = 8;
  localparam int          V    = 4;
  localparam int          BL   = 4;
  localparam int          PC   = 2;
  localparam int          NPIX = H * V;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd2;
  logic [23:0] solid_rgb = 24'h123456;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic        wshb_cyc, wshb_stb, wshb_we, frame_done;
  logic [31:0] wshb_adr, wshb_dat_ms;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;

  always #5 clk = ~clk;

  wshb_mire_gen #(
    .HDISP(H), .VDISP(V), .BURST_LEN(BL), .PAUSE_CYCLES(PC), .BASE_ADR(BASE)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we),
    .wshb_adr(wshb_adr), .wshb_dat_ms(wshb_dat_ms), .wshb_sel(wshb_sel),
    .wshb_cti(wshb_cti), .wshb_bte(wshb_bte), .wshb_ack(ack),
    .wshb_err(err), .wshb_rty(rty), .frame_done(frame_done)
  );

  int passed = 0, total = 0, failed = 0;

  // Reference model state
  int          pix, burst_acc, frames, gap, err_left, wait_n, delay, fixed_delay;
  bit          exp_fd, prev_cyc, in_gap, gap_ok, rnd_mode;
  logic [1:0]  m_pat;
  logic [23:0] m_solid;
  logic [23:0] bar_tab [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int p);
    int x, y, xs, b;
    x = p % H;
    y = p / H;
`ifdef MIRE_ANIM_EN
    xs = (x + frames) % H;
`else
    xs = x;
`endif
    case (m_pat)
      2'd0: begin
        b = xs / (H / 8);
        if (b > 7) b = 7;
        model_rgb = bar_tab[b];
      end
      2'd1: model_rgb = (((xs / 16) % 2) != ((y / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
      2'd2: model_rgb = m_solid;
      default: model_rgb = {3{8'(xs % 256)}};
    endcase
  endfunction

  task automatic model_reset();
    pix = 0; burst_acc = 0; frames = 0; gap = 0; err_left = 0; wait_n = 0;
    exp_fd = 0; prev_cyc = 0; in_gap = 0; gap_ok = 0;
    m_pat = pattern_sel; m_solid = solid_rgb;
  endtask

  // One clock: observe/check at the falling edge, then drive the slave reply
  // that the DUT samples at the following rising edge.
  task automatic step();
    bit acc;
    @(negedge clk);
    acc = 0;
    if (rst) begin
      ack = 0; err = 0; rty = 0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      if (wshb_stb) begin
        chk("cyc_we", 32'({wshb_cyc, wshb_we}), 32'h3);
        chk("sel_cti_bte", 32'({wshb_sel, wshb_cti, wshb_bte}), 32'h1E0);
        chk("adr", wshb_adr, BASE + 32'(4 * pix));
        chk("dat", wshb_dat_ms, {8'h00, model_rgb(pix)});
      end
      if (prev_cyc && !wshb_cyc) begin
        chk("burst_len", 32'(burst_acc), 32'(BL));
        burst_acc = 0; gap = 0; gap_ok = 1; in_gap = 1;
      end
      if (!prev_cyc && wshb_cyc && in_gap && gap_ok) chk("pause_len", 32'(gap), 32'(PC));
      if (wshb_cyc) in_gap = 0;
      if (!wshb_cyc && in_gap) begin
        gap++;
        if (!enable) gap_ok = 0;
      end
      prev_cyc = wshb_cyc;

      if (!wshb_stb) begin
        ack = 0; err = 0; rty = 0;
      end else if (err_left > 0) begin
        err = 1; rty = 0; ack = 1'($urandom_range(0, 1)); err_left--;
      end else if (rnd_mode && $urandom_range(0, 9) == 0) begin
        rty = 1; err = 0; ack = 1'($urandom_range(0, 1));
      end else if (wait_n < delay) begin
        ack = 0; err = 0; rty = 0; wait_n++;
      end else begin
        ack = 1; err = 0; rty = 0; acc = 1;
      end

      exp_fd = 0;
      if (acc) begin
        wait_n = 0;
        delay  = rnd_mode ? $urandom_range(0, 2) : fixed_delay;
        burst_acc++;
        if (pix == NPIX - 1) begin
          exp_fd = 1;
          frames++;
          m_pat = pattern_sel;
          m_solid = solid_rgb;
        end
        pix = (pix + 1) % NPIX;
      end
    end
  endtask

  task automatic run_until_pix(input int target);
    int n = 0;
    while (pix != target && n < 500) begin step(); n++; end
    chk("reach_pix", 32'(pix), 32'(target));
  endtask

  task automatic run_until_acc(input int target);
    int n = 0;
    while (burst_acc != target && n < 500) begin step(); n++; end
    chk("reach_acc", 32'(burst_acc), 32'(target));
  endtask

  task automatic wait_frames(input int k);
    int n = 0;
    int target;
    target = frames + k;
    while (frames < target && n < 2000) begin step(); n++; end
    chk("reach_frame", 32'(frames >= target), 32'h1);
  endtask

  initial begin
    int n;
    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    rnd_mode = 0; fixed_delay = 0; delay = 0;
    model_reset();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_cyc", 32'(wshb_cyc), 32'h0);
    chk("rst_stb_we", 32'({wshb_stb, wshb_we}), 32'h0);
    chk("rst_adr", wshb_adr, BASE);
    chk("rst_dat", wshb_dat_ms, 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_sel", 32'(wshb_sel), 32'hF);
    rst = 0;
    model_reset();
    enable = 1;

    // Solid pattern: first two bursts and the pause between them
    run_until_pix(8);

    // Colour bars from the next frame, then one full bar frame
    pattern_sel = 2'd0;
    wait_frames(2);

    // err on the second transfer of a burst for 3 cycles
    run_until_pix(9);
    run_until_acc(1);
    err_left = 3;
    run_until_acc(0);

    // Slave acking 2 cycles late for a whole frame
    fixed_delay = 2; delay = 2;
    wait_frames(1);
    fixed_delay = 0; delay = 0;

    // Solid frame, switch to checker at pixel 10, then a checker frame
    run_until_pix(12);
    pattern_sel = 2'd2;
    solid_rgb = 24'hA5C3E1;
    wait_frames(1);
    run_until_pix(10);
    pattern_sel = 2'd1;
    wait_frames(2);

    // Drop enable mid-burst: burst completes, then idle, then resume
    run_until_pix(6);
    run_until_acc(1);
    enable = 0;
    n = 0;
    while (wshb_cyc && n < 50) begin step(); n++; end
    repeat (6) step();
    chk("idle_cyc", 32'(wshb_cyc), 32'h0);
    chk("idle_stb", 32'(wshb_stb), 32'h0);
    enable = 1;
    run_until_acc(2);

    // Asynchronous reset mid-burst
    run_until_acc(2);
    #2;
    rst = 1; ack = 0; err = 0; rty = 0;
    #1;
    chk("arst_cyc", 32'(wshb_cyc), 32'h0);
    chk("arst_stb", 32'(wshb_stb), 32'h0);
    chk("arst_adr", wshb_adr, BASE);
    step();
    step();
    rst = 0;
    model_reset();
    wait_frames(1);

    // Randomised slave (delays, retries) with pattern and enable changes
    rnd_mode = 1;
    for (int i = 0; i < 900; i++) begin
      step();
      if (pix >= 5 && pix <= 25 && $urandom_range(0, 30) == 0) begin
        pattern_sel = 2'($urandom_range(0, 3));
        solid_rgb   = 24'($urandom);
      end
      if (wshb_cyc && $urandom_range(0, 20) == 0) enable = ($urandom_range(0, 3) != 0);
      if (!enable && !wshb_cyc && $urandom_range(0, 10) == 0) enable = 1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
